rt_note_sequencer: RTL
======================

# rt_note_sequencer

Upstream song sequencer for `rt_noteplayer`. It walks a song ROM of `{note, duration}` entries and presents each note on `note_to_load` for `duration` beats. Beats come as pulses from `beat_generator`. It pauses with `play_enable`, stops at an end-of-song marker, and restarts on request.

## Interface
Parameters:
- `ADDR_W`, 7: song ROM address width (128 entries).
- `NOTE_W`, 6: note code width. Note 0 is a rest.
- `DUR_W`, 6: duration width, in beats. Duration 0 is the end-of-song marker.

Ports:
- `clk`  in  1  system clock. All state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `play_enable`  in  1  1 = beats are counted; 0 = playback frozen.
- `restart`  in  1  synchronous one-cycle pulse: rewind to entry 0.
- `beat`  in  1  one-cycle beat pulse from `beat_generator`.
- `rom_addr`  out  ADDR_W  song ROM address (registered).
- `rom_data`  in  NOTE_W+DUR_W  `{note, duration}`. Comes from a synchronous ROM with 1-cycle read latency.
- `note_to_load`  out  NOTE_W  current note to `rt_noteplayer`.
- `new_note`  out  1  one-cycle pulse in the cycle `note_to_load` takes a new entry's value.
- `beats_left`  out  DUR_W  remaining beats of the current note.
- `song_done`  out  1  high while in DONE.

## Operation
- Reset values: `rom_addr`=0, `note_to_load`=0, `new_note`=0, `beats_left`=0, `song_done`=0, state=FETCH.
- FETCH (1 cycle): `rom_addr` is stable; the ROM samples it at the edge ending this state. Next state is WAIT.
- WAIT (1 cycle): `rom_data` is valid. The edge ending WAIT captures it and moves to:
  - DONE if duration==0, or
  - PLAY otherwise. In this case `note_to_load`←note, `beats_left`←duration, and `new_note`=1 for the first PLAY cycle.
- PLAY, on `beat && play_enable`:
  - If `beats_left`==1: `beats_left`←0, `rom_addr`←`rom_addr`+1, go to FETCH.
  - Otherwise: `beats_left` decrements by 1.
- PLAY when `rom_addr` is the last address (all ones) and its last beat expires: go to DONE, no wrap-around.
- DONE: `note_to_load`=0, `song_done`=1. Stays until `restart`.
- `restart` in any state has priority over `beat`:
  - next cycle: `rom_addr`=0, state=FETCH, `song_done`=0, `note_to_load`=0, `beats_left`=0.
- `play_enable`=0:
  - PLAY ignores `beat`; `note_to_load` and `beats_left` hold.
  - FETCH/WAIT complete normally, so a pending load is never lost.
  - `play_enable` does not gate `restart`.
- During FETCH/WAIT, `note_to_load` keeps the previous note, so there is no glitch into the note player.
- Note value 0 (rest) with nonzero duration is played like any other entry: held for its beats.
- Arithmetic is unsigned. `beats_left` never underflows: the decrement is only taken when it is ≥2.

## Timing
- Entry transition: the last beat edge → FETCH → WAIT → new note in PLAY. The new note appears 2 cycles after the beat edge, with `new_note` high in that cycle.
- Beats arriving in FETCH or WAIT are dropped. System constraint: beat period ≥ 4 cycles (the `beat_generator` period is far larger).
- From reset deassertion, the first note appears after 2 edges, with a `new_note` pulse.
- `restart` latency is 1 cycle to FETCH; the first note follows 2 cycles later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header `rt_seq_pkg`:
  - state encoding FETCH/WAIT/PLAY/DONE,
  - `DUR_END`=0,
  - `NOTE_REST`=0,
  - default widths.
- The ROM is external and instantiated by the top level, so songs can be swapped.
- One natural sub-module: `beat_countdown`.
  - Loadable down-counter of width `DUR_W`.
  - Inputs: `load`, `load_val`, `dec`.
  - Outputs: `count` and `last` (count==1).
- The FSM, address register and note register live in `rt_note_sequencer`.

## Test plan
- ROM = {(40,3),(44,2),(0,0 end)}, `play_enable`=1, beat every 20 cycles:
  - `note_to_load` = 40 for 3 beats, then 44 for 2 beats, then `song_done`=1 and `note_to_load`=0;
  - exactly two `new_note` pulses.
- Same ROM; `play_enable` drops after the first beat of note 40 and stays low for 5 beats, then rises:
  - `beats_left` holds at 2 throughout;
  - note 40 then lasts 2 more beats.
- `restart` pulsed in the same cycle as the last beat of note 44:
  - `rom_addr`=0 the next cycle; no DONE;
  - note 40 reloads with `beats_left`=3.
- ROM fully populated with duration 1 and no end marker:
  - after entry 127 plays, DONE is entered;
  - `rom_addr` stays at 127 and does not wrap to 0.
- `reset` asserted asynchronously mid-PLAY (between edges):
  - all outputs go to their reset values immediately;
  - after deassertion, the first note appears 2 edges later.
- Entry (0,4), a rest:
  - `note_to_load`=0 for 4 beats with `song_done`=0;
  - a `beat` injected in WAIT is dropped and the count is unchanged.

Source files
------------

// File: rtl/rt_seq_pkg.sv
// Shared constants for the song sequencer: default widths, state codes, markers.
package rt_seq_pkg;

    localparam int unsigned SEQ_ADDR_W = 7;
    localparam int unsigned SEQ_NOTE_W = 6;
    localparam int unsigned SEQ_DUR_W  = 6;

    // Sequencer state encoding
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Duration 0 terminates the song; note 0 is a rest
    localparam logic [SEQ_DUR_W-1:0]  DUR_END   = '0;
    localparam logic [SEQ_NOTE_W-1:0] NOTE_REST = '0;

    // Song ROM word layout at the default widths: {note, duration}
    typedef struct packed {
        logic [SEQ_NOTE_W-1:0] note;
        logic [SEQ_DUR_W-1:0]  dur;
    } song_entry_t;

endpackage

// File: rtl/beat_countdown.sv
// Loadable beat down-counter; last flags a count of exactly one.
module beat_countdown #(
    parameter int unsigned DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             dec,
    output logic [DUR_W-1:0] count,
    output logic             last
);

    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;
    logic             last_q;

    // Load has priority; decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - DUR_W'(1);
        end
    end

    // Count register with a registered last-beat flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == DUR_W'(1));
        end
    end

    assign count = count_q;
    assign last  = last_q;

endmodule

// File: rtl/rt_note_sequencer.sv
// Walks a {note, duration} song ROM and presents each note for its beats.
module rt_note_sequencer
    import rt_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = SEQ_ADDR_W,
    parameter int unsigned NOTE_W = SEQ_NOTE_W,
    parameter int unsigned DUR_W  = SEQ_DUR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play_enable,
    input  logic                    restart,
    input  logic                    beat,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_to_load,
    output logic                    new_note,
    output logic [DUR_W-1:0]        beats_left,
    output logic                    song_done
);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [NOTE_W-1:0] note_q,     note_d;
    logic              new_note_q, new_note_d;
    logic              done_q,     done_d;

    logic              cnt_load;
    logic [DUR_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic [DUR_W-1:0]  cnt_count;
    logic              cnt_last;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              advance;
    logic              addr_is_last;

    assign rom_note     = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur      = rom_data[DUR_W-1:0];
    assign advance      = beat && play_enable;
    assign addr_is_last = (addr_q == {ADDR_W{1'b1}});

    beat_countdown #(
        .DUR_W (DUR_W)
    ) u_beat_countdown (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .last     (cnt_last)
    );

    // Next-state logic; restart outranks everything, FETCH/WAIT ignore beats
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        note_d       = note_q;
        new_note_d   = 1'b0;
        done_d       = done_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (restart) begin
            state_d  = ST_FETCH;
            addr_d   = '0;
            note_d   = NOTE_W'(NOTE_REST);
            done_d   = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_dur == DUR_W'(DUR_END)) begin
                        state_d  = ST_DONE;
                        note_d   = NOTE_W'(NOTE_REST);
                        done_d   = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        state_d      = ST_PLAY;
                        note_d       = rom_note;
                        new_note_d   = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = rom_dur;
                    end
                end
                ST_PLAY: begin
                    if (advance) begin
                        cnt_dec = 1'b1;
                        if (cnt_last) begin
                            if (addr_is_last) begin
                                state_d = ST_DONE;
                                note_d  = NOTE_W'(NOTE_REST);
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_FETCH;
                                addr_d  = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    note_d = NOTE_W'(NOTE_REST);
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // State, address and note registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            addr_q     <= '0;
            note_q     <= '0;
            new_note_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            note_q     <= note_d;
            new_note_q <= new_note_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr     = addr_q;
    assign note_to_load = note_q;
    assign new_note     = new_note_q;
    assign beats_left   = cnt_count;
    assign song_done    = done_q;

endmodule
